seq_alu: RTL

Parametrised, multi-cycle successor to the team's 20-bit combinational ALU. Add, sub and the bitwise ops finish in one clock. Multiply and divide run as iterative shift-add and restoring-division engines over WIDTH cycles. The block uses a start/busy/done handshake, registered results and a zero flag that is valid for every result. It sits between the datapath register file and the result writeback mux.

---
 rtl/seq_alu_pkg.sv | 22 ++
 rtl/seq_alu_iter.sv | 84 ++++++++
 rtl/seq_alu.sv | 118 +++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode and state definitions for the sequential ALU.
package seq_alu_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    localparam logic ITER_MUL = 1'b0;
    localparam logic ITER_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Shared WIDTH-cycle shift engine: shift-add multiplier (low half) and restoring divider.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             mode,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             finish,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH);

    // r: accumulator / partial remainder, s: multiplicand / dividend->quotient,
    // d: multiplier (shifted right) / divisor
    logic [WIDTH-1:0] r_q, r_d, s_q, s_d, d_q, d_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   trial, diff;

    always_comb begin
        r_d    = r_q;
        s_d    = s_q;
        d_d    = d_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        finish = 1'b0;
        trial  = {r_q, s_q[WIDTH-1]};
        diff   = trial - {1'b0, d_q};

        if (load) begin
            r_d    = '0;
            s_d    = a;
            d_d    = b;
            mode_d = mode;
            cnt_d  = '0;
        end else if (step) begin
            if (mode_q == ITER_DIV) begin
                // Top bit of diff is a borrow: clear means trial >= divisor.
                if (!diff[WIDTH]) begin
                    r_d = diff[WIDTH-1:0];
                    s_d = {s_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = trial[WIDTH-1:0];
                    s_d = {s_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_d = r_q + (d_q[0] ? s_q : '0);
                s_d = {s_q[WIDTH-2:0], 1'b0};
                d_d = {1'b0, d_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                finish = 1'b1;
                cnt_d  = '0;
            end
        end

        result = (mode_q == ITER_DIV) ? s_d : r_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            s_q    <= '0;
            d_q    <= '0;
            mode_q <= ITER_MUL;
            cnt_q  <= '0;
        end else begin
            r_q    <= r_d;
            s_q    <= s_d;
            d_q    <= d_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/add/sub, iterative mul/div, start/busy/done handshake.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic             zero_check,
    output logic             div_by_zero
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d, alu_res, iter_result;
    logic             zero_q, zero_d, dbz_q, dbz_d, done_q, done_d;
    logic             iter_load, iter_mode, iter_step, iter_finish;

    seq_alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (iter_load),
        .mode   (iter_mode),
        .step   (iter_step),
        .a      (a),
        .b      (b),
        .finish (iter_finish),
        .result (iter_result)
    );

    // Single-cycle results; the DIV entry only applies to divide-by-zero.
    always_comb begin
        alu_res = '0;
        case (sel)
            OP_PASS: alu_res = a;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_DIV:  alu_res = '1;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        zero_d    = zero_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        iter_load = 1'b0;
        iter_mode = ITER_MUL;
        iter_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (sel == OP_MUL) begin
                        iter_load = 1'b1;
                        state_d   = ST_MUL;
                    end else if (sel == OP_DIV && b != '0) begin
                        iter_load = 1'b1;
                        iter_mode = ITER_DIV;
                        state_d   = ST_DIV;
                    end else begin
                        c_d    = alu_res;
                        zero_d = (alu_res == '0);
                        dbz_d  = (sel == OP_DIV);
                        done_d = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                iter_step = 1'b1;
                if (iter_finish) begin
                    c_d     = iter_result;
                    zero_d  = (iter_result == '0);
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign c           = c_q;
    assign zero_check  = zero_q;
    assign div_by_zero = dbz_q;

endmodule
